dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the CPU load/store port and a

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_age_cnt.sv | 28 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_age_cnt.sv
// rtl/dmem_arb_age_cnt.sv - saturating host wait counter; sat forces a host grant
module dmem_arb_age_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q < CW'(MAX_WAIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q >= CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host single-port data memory arbiter, CPU priority
// Optional host aging under DMEM_ARB_AGE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
`ifdef DMEM_ARB_AGE_EN
    ,
    parameter int MAX_WAIT = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic          we_q;
    logic [LW-1:0] lat_q;
    logic          grant_cpu;
    logic          grant_host;
    logic          host_first;
    logic          sample_rd;

`ifdef DMEM_ARB_AGE_EN
    logic age_sat;

    dmem_arb_age_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age_cnt (
        .clk(clk),
        .rst(rst),
        .inc(host_req & ~grant_host),
        .clr(grant_host),
        .sat(age_sat)
    );

    assign host_first = age_sat;
`else
    assign host_first = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_cpu  = 1'b0;
        grant_host = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        cpu_ack    = 1'b0;
        host_ack   = 1'b0;
        sample_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req && (!cpu_req || host_first)) begin
                    grant_host = 1'b1;
                    state_d    = ISSUE;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = we_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    sample_rd = ~we_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                cpu_ack  = (owner_q == OWN_CPU);
                host_ack = (owner_q == OWN_HOST);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Address/data are captured once at grant so requester changes mid-flight are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_CPU;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_q      <= '0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (grant_cpu) begin
                owner_q   <= OWN_CPU;
                we_q      <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grant_host) begin
                owner_q   <= OWN_HOST;
                we_q      <= host_we;
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
            end
            if (state_q == ISSUE) begin
                lat_q <= LW'(MEM_LAT - 1);
            end else if ((state_q == WAIT) && (lat_q != '0)) begin
                lat_q <= lat_q - 1'b1;
            end
            if (sample_rd) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata <= mem_rdata;
                end else begin
                    host_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        host_req, host_we, host_ack;
    logic [15:0] host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        d3_cpu_req, d3_cpu_we, d3_cpu_ack;
    logic [15:0] d3_cpu_addr;
    logic [31:0] d3_cpu_wdata, d3_cpu_rdata;
    logic        d3_host_req, d3_host_we, d3_host_ack;
    logic [15:0] d3_host_addr;
    logic [31:0] d3_host_wdata, d3_host_rdata;
    logic        d3_mem_en, d3_mem_we, d3_busy;
    logic [15:0] d3_mem_addr;
    logic [31:0] d3_mem_wdata, d3_mem_rdata;

    int checks;
    int errors;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
        .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata),
        .host_req(d3_host_req), .host_we(d3_host_we), .host_addr(d3_host_addr),
        .host_wdata(d3_host_wdata), .host_ack(d3_host_ack), .host_rdata(d3_host_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(d3_mem_rdata), .busy(d3_busy)
    );

    always #5 clk = ~clk;

    // Single-port memories: one with 1-cycle read latency, one with 3-cycle.
    logic [31:0] mem1 [0:65535];
    logic [31:0] mem3 [0:65535];
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem1[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (d3_mem_en) begin
            if (d3_mem_we) mem3[d3_mem_addr] <= d3_mem_wdata;
            else           p0 <= mem3[d3_mem_addr];
        end
        p1           <= p0;
        d3_mem_rdata <= p1;
    end

    task automatic txn(input bit host, input logic w, input logic [15:0] a,
                       input logic [31:0] d, output int lat, output int ens,
                       output logic [31:0] rd);
        lat = -1; ens = 0; rd = '0;
        if (host) begin
            host_req = 1'b1; host_we = w; host_addr = a; host_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        end
        for (int c = 0; c < 20; c++) begin
            if (mem_en) ens++;
            if (host ? host_ack : cpu_ack) begin
                lat = c;
                rd  = host ? host_rdata : cpu_rdata;
                break;
            end
            @(negedge clk);
        end
        if (host) host_req = 1'b0;
        else      cpu_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic txn3(input logic w, input logic [15:0] a, input logic [31:0] d,
                        output int lat, output int ens, output logic [31:0] rd);
        lat = -1; ens = 0; rd = '0;
        d3_cpu_req = 1'b1; d3_cpu_we = w; d3_cpu_addr = a; d3_cpu_wdata = d;
        for (int c = 0; c < 20; c++) begin
            if (d3_mem_en) ens++;
            if (d3_cpu_ack) begin
                lat = c;
                rd  = d3_cpu_rdata;
                break;
            end
            @(negedge clk);
        end
        d3_cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, mem_en, mem_we, cpu_ack, host_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, mem_en, mem_we, cpu_ack, host_ack});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, host_rdata} !== 112'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, cpu_rdata, host_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got %b want 0", busy);
        end
    endtask

    task automatic test_host_rw();
        int lat, ens;
        logic [31:0] rd;
        txn(1'b1, 1'b1, 16'h0004, 32'hDEADBEEF, lat, ens, rd);
        checks++;
        if (lat !== 3 || ens !== 1) begin
            errors++;
            $display("FAIL host_write lat %0d en %0d want 3 1", lat, ens);
        end
        txn(1'b1, 1'b1, 16'h0010, 32'h12345678, lat, ens, rd);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL host_write2 lat %0d want 3", lat);
        end
        txn(1'b1, 1'b0, 16'h0004, 32'h0, lat, ens, rd);
        checks++;
        if (lat !== 3 || ens !== 1) begin
            errors++;
            $display("FAIL host_read lat %0d en %0d want 3 1", lat, ens);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL host_rdata got %h want deadbeef", rd);
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL cpu_rdata_untouched got %h want 0", cpu_rdata);
        end
    endtask

    task automatic test_priority();
        int cl, hl, both;
        logic [31:0] crd, hrd;
        cl = -1; hl = -1; both = 0; crd = '0; hrd = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0004;
        for (int c = 0; c < 15; c++) begin
            if (cpu_ack && host_ack) both++;
            if (cpu_ack && cl < 0) begin cl = c; crd = cpu_rdata; end
            if (host_ack && hl < 0) begin hl = c; hrd = host_rdata; end
            if (cpu_ack) cpu_req = 1'b0;
            if (host_ack) host_req = 1'b0;
            @(negedge clk);
        end
        cpu_req = 1'b0; host_req = 1'b0;
        checks++;
        if (cl !== 3 || hl !== 7) begin
            errors++;
            $display("FAIL prio_order cpu_ack %0d host_ack %0d want 3 7", cl, hl);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL prio_both_acks got %0d want 0", both);
        end
        checks++;
        if (crd !== 32'h12345678 || hrd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL prio_rdata cpu %h host %h want 12345678 deadbeef", crd, hrd);
        end
    endtask

    task automatic test_lat3();
        int lat, ens;
        logic [31:0] rd;
        txn3(1'b1, 16'h0020, 32'hCAFEF00D, lat, ens, rd);
        checks++;
        if (lat !== 5 || ens !== 1) begin
            errors++;
            $display("FAIL lat3_store lat %0d en %0d want 5 1", lat, ens);
        end
        txn3(1'b0, 16'h0020, 32'h0, lat, ens, rd);
        checks++;
        if (lat !== 5 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lat3_load lat %0d rdata %h want 5 cafef00d", lat, rd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ens, acks;
        logic [31:0] rd;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy got %b want 1", busy);
        end
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if ({busy, mem_en, mem_we, cpu_ack, host_ack} !== 5'b0 ||
            {mem_addr, mem_wdata, cpu_rdata, host_rdata} !== 112'h0) begin
            errors++;
            $display("FAIL midrst_outputs ctrl %b data %h want 0", {busy, mem_en, mem_we, cpu_ack, host_ack},
                     {mem_addr, mem_wdata, cpu_rdata, host_rdata});
        end
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_ack || host_ack) acks++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_ack || host_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL midrst_no_ack got %0d want 0", acks);
        end
        txn(1'b0, 1'b0, 16'h0004, 32'h0, lat, ens, rd);
        checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midrst_fresh lat %0d rdata %h want 3 deadbeef", lat, rd);
        end
    endtask

    task automatic test_addr_hold();
        int lat, ens;
        logic [31:0] rd;
        bit moved;
        lat = -1; moved = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h0BADF00D;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                cpu_addr = 16'h0031; cpu_wdata = 32'h11111111;
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0030 ||
                    mem_wdata !== 32'h0BADF00D) begin
                    errors++;
                    $display("FAIL hold_issue en %b we %b addr %h data %h want 1 1 0030 0badf00d",
                             mem_en, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c > 1 && mem_addr !== 16'h0030) moved = 1'b1;
            if (cpu_ack) begin lat = c; break; end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (lat !== 3 || moved) begin
            errors++;
            $display("FAIL hold_store lat %0d addr_moved %0d want 3 0", lat, moved);
        end
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_keeps_rdata got %h want deadbeef", cpu_rdata);
        end
        txn(1'b0, 1'b0, 16'h0030, 32'h0, lat, ens, rd);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL hold_readback got %h want 0badf00d", rd);
        end
    endtask

    task automatic test_age();
        int cacks, hacks, hfirst, both;
        int exp_c, exp_h, exp_hf;
`ifdef DMEM_ARB_AGE_EN
        exp_c = 9; exp_h = 1; exp_hf = 11;
`else
        exp_c = 10; exp_h = 0; exp_hf = -1;
`endif
        cacks = 0; hacks = 0; hfirst = -1; both = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0004;
        for (int c = 0; c < 40; c++) begin
            if (cpu_ack && host_ack) both++;
            if (cpu_ack) cacks++;
            if (host_ack) begin
                hacks++;
                if (hfirst < 0) hfirst = c;
                host_req = 1'b0;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0; host_req = 1'b0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        checks++;
        if (hacks !== exp_h || hfirst !== exp_hf) begin
            errors++;
            $display("FAIL age_host acks %0d first %0d want %0d %0d", hacks, hfirst, exp_h, exp_hf);
        end
        checks++;
        if (cacks !== exp_c || both !== 0) begin
            errors++;
            $display("FAIL age_cpu acks %0d both %0d want %0d 0", cacks, both, exp_c);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL age_drain busy got %b want 0", busy);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        checks = 0; errors = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        d3_cpu_req = 0; d3_cpu_we = 0; d3_cpu_addr = '0; d3_cpu_wdata = '0;
        d3_host_req = 0; d3_host_we = 0; d3_host_addr = '0; d3_host_wdata = '0;
        test_reset();
        test_host_rw();
        test_priority();
        test_lat3();
        test_reset_mid();
        test_addr_hold();
        test_age();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
